// File: rtl/io_map_pkg.sv
// Shared IO address map and seven-segment encoding helpers for the IO port banks.
package io_map_pkg;

    localparam logic [5:0] IO_OUT0 = 6'b100000;
    localparam logic [5:0] IO_OUT1 = 6'b100001;
    localparam logic [5:0] IO_OUT2 = 6'b100010;
    localparam logic [5:0] IO_IN0  = 6'b110000;
    localparam logic [5:0] IO_IN1  = 6'b110001;

    localparam int N_OUT_PORTS = 3;

    // Cathode bit positions in {dp,g,f,e,d,c,b,a}; all segments active-low.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;
    localparam logic [7:0] AN_DIGIT0   = 8'hFE;

    typedef enum logic [1:0] {
        PSEL_OUT0 = 2'd0,
        PSEL_OUT1 = 2'd1,
        PSEL_OUT2 = 2'd2,
        PSEL_NONE = 2'd3
    } port_sel_e;

    function automatic port_sel_e decode_out_port(input logic [5:0] word_addr);
        case (word_addr)
            IO_OUT0: decode_out_port = PSEL_OUT0;
            IO_OUT1: decode_out_port = PSEL_OUT1;
            IO_OUT2: decode_out_port = PSEL_OUT2;
            default: decode_out_port = PSEL_NONE;
        endcase
    endfunction

    // Hex glyphs with the decimal point forced off.
    function automatic logic [7:0] seg7_hex(input logic [3:0] nibble);
        case (nibble)
            4'h0: seg7_hex = 8'hC0;
            4'h1: seg7_hex = 8'hF9;
            4'h2: seg7_hex = 8'hA4;
            4'h3: seg7_hex = 8'hB0;
            4'h4: seg7_hex = 8'h99;
            4'h5: seg7_hex = 8'h92;
            4'h6: seg7_hex = 8'h82;
            4'h7: seg7_hex = 8'hF8;
            4'h8: seg7_hex = 8'h80;
            4'h9: seg7_hex = 8'h90;
            4'hA: seg7_hex = 8'h88;
            4'hB: seg7_hex = 8'h83;
            4'hC: seg7_hex = 8'hC6;
            4'hD: seg7_hex = 8'hA1;
            4'hE: seg7_hex = 8'h86;
            default: seg7_hex = 8'h8E;
        endcase
    endfunction

endpackage

// File: rtl/io_seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner: prescaler, digit index and
// registered anode/cathode drive with per-digit blanking.
module io_seg7_scan
    import io_map_pkg::*;
#(
    parameter int SCAN_DIV_W = 16
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] value,
    input  logic [7:0]  blank,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    logic [SCAN_DIV_W-1:0] r_prescale;
    logic [2:0]            r_digit;
    logic [7:0]            r_seg_an;
    logic [7:0]            r_seg_cat;

    logic                  w_wrap;
    logic [2:0]            w_digit_next;
    logic [3:0]            w_nibble;

    assign w_wrap       = &r_prescale;
    assign w_digit_next = r_digit + 3'd1;
    assign w_nibble     = value[{w_digit_next, 2'b00} +: 4];

    // Drive is computed for the digit being entered, so anode and cathode
    // change together on the wrap edge.
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_prescale <= '0;
            r_digit    <= 3'd0;
            r_seg_an   <= AN_DIGIT0;
            r_seg_cat  <= seg7_hex(4'h0);
        end else begin
            r_prescale <= r_prescale + 1'b1;
            if (w_wrap) begin
                r_digit <= w_digit_next;
                if (blank[w_digit_next]) begin
                    r_seg_an  <= SEG_ALL_OFF;
                    r_seg_cat <= SEG_ALL_OFF;
                end else begin
                    r_seg_an  <= ~(8'h01 << w_digit_next);
                    r_seg_cat <= seg7_hex(w_nibble);
                end
            end
        end
    end

    assign seg_an  = r_seg_an;
    assign seg_cat = r_seg_cat;

endmodule

// File: rtl/io_output_reg.sv
// Memory-mapped output port bank: three store-written registers with
// combinational readback, plus a hex display of out_port0.
module io_output_reg
    import io_map_pkg::*;
#(
    parameter int SCAN_DIV_W = 16
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    output logic [31:0] io_read_data,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    logic [31:0] r_port [N_OUT_PORTS];
    port_sel_e   w_sel;
    logic        w_addr_unused;

    assign w_sel = decode_out_port(addr[7:2]);
    // Only the word-select field participates in decoding.
    assign w_addr_unused = ^{addr[31:8], addr[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT_PORTS; gi++) begin : g_port
            always_ff @(posedge io_clk or negedge resetn) begin
                if (!resetn) begin
                    r_port[gi] <= 32'h0;
                end else if (write_io_enable && (w_sel == port_sel_e'(gi))) begin
                    r_port[gi] <= datain;
                end
            end
        end
    endgenerate

    always_comb begin
        io_read_data = 32'h0;
        case (w_sel)
            PSEL_OUT0: io_read_data = r_port[0];
            PSEL_OUT1: io_read_data = r_port[1];
            PSEL_OUT2: io_read_data = r_port[2];
            default:   io_read_data = 32'h0;
        endcase
    end

    assign out_port0 = r_port[0];
    assign out_port1 = r_port[1];
    assign out_port2 = r_port[2];

    io_seg7_scan #(
        .SCAN_DIV_W (SCAN_DIV_W)
    ) u_scan (
        .io_clk  (io_clk),
        .resetn  (resetn),
        .value   (r_port[0]),
        .blank   (r_port[2][7:0]),
        .seg_an  (seg_an),
        .seg_cat (seg_cat)
    );

endmodule
